fp_mul_arbiter: RTL

Shares one fixed-latency pipelined 32-bit FP multiplier among NREQ requesters.
- Round-robin arbitration with per-requester valid/ready handshake.
- Per-requester outstanding-operation credit limit.
- Requester-ID tag travels through a shift register matched to the multiplier latency, so each product is routed back to its originator.
- Sits between the client units and the FP multiplier instance. The multiplier has no valid, stall or enable, so all sequencing lives here.

---
 rtl/fp_mul_arbiter_if.sv | 36 +++
 rtl/fp_mul_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fp_mul_arbiter_if.sv
// fp_mul_arbiter_if: client-side bundle of the shared FP multiplier arbiter.
//
// Handshake: on every rising edge where req_valid[i] and req_ready[i] are both
// high, requester i's operands are taken. A requester keeps req_valid high and
// its operands stable until that edge. req_ready is one-hot or zero. The
// response side (rsp_valid/rsp_data) has no backpressure: each rsp_valid pulse
// lasts one cycle and the requester must take it.
//
// Signals:
//   req_valid  [NREQ]     requester i presents operands
//   req_ready  [NREQ]     requester i granted this cycle
//   req_a/b    [32*NREQ]  operands, requester i at [32i+31:32i]
//   rsp_valid  [NREQ]     one-hot, product for requester i
//   rsp_data   [32]       product
//   busy                  any operation issued and not yet returned
interface fp_mul_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [32*NREQ-1:0]   req_a;
  logic [32*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      rsp_valid;
  logic [31:0]          rsp_data;
  logic                 busy;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: shares one fixed-latency pipelined FP multiplier among NREQ
// requesters. Round-robin grant, per-requester credit limit on in-flight ops,
// and a tag shift register matched to the multiplier latency that routes each
// product back to the requester that issued it. The multiplier has no valid or
// stall, so every cycle issues either a real op or zero operands.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   cli       fp_mul_arbiter_if.slave (requests, responses, busy)
//   mul_a/b   registered operands to the multiplier
//   mul_prod  multiplier product, LAT cycles after mul_a/mul_b
module fp_mul_arbiter #(
  parameter int NREQ   = 4,
  parameter int TAGW   = 2,
  parameter int LAT    = 6,
  parameter int MAXOUT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp_mul_arbiter_if.slave      cli,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [31:0]          mul_prod
);

  logic [TAGW-1:0]  ptr;
  logic [2:0]       cnt [NREQ];

  // Tag pipe: stage s holds the owner of the op whose product reaches
  // mul_prod when the tag reaches stage LAT.
  logic             tag_v  [LAT+1];
  logic [TAGW-1:0]  tag_id [LAT+1];

  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  grant_oh;
  logic [TAGW-1:0]  grant_idx;
  logic             grant_found;
  logic             accept;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic [NREQ-1:0]  inc_vec;
  logic [NREQ-1:0]  dec_vec;
  logic [NREQ-1:0]  rsp_oh;

  // Eligibility looks only at registered credits, so a credit returned at an
  // edge is usable in the cycle right after that edge and never earlier.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = cli.req_valid[i] && (cnt[i] < 3'(MAXOUT));
    end
  end

  // Round-robin scan starting just after the last accepted requester.
  always_comb begin
    logic [TAGW-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = TAGW'((int'(ptr) + k) % NREQ);
      if (!grant_found && elig[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (grant_found && rst_n) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  assign cli.req_ready = grant_oh;
  assign accept        = |(cli.req_valid & grant_oh);

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == TAGW'(i)) begin
        sel_a = cli.req_a[32*i +: 32];
        sel_b = cli.req_b[32*i +: 32];
      end
    end
  end

  // Credit events at the coming edge: an accept takes a credit, a response
  // issue (tag at the last stage) gives one back.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    rsp_oh  = '0;
    for (int i = 0; i < NREQ; i++) begin
      inc_vec[i] = accept && (grant_idx == TAGW'(i));
      dec_vec[i] = tag_v[LAT] && (tag_id[LAT] == TAGW'(i));
      rsp_oh[i]  = (tag_id[LAT] == TAGW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_a         <= '0;
      mul_b         <= '0;
      cli.rsp_valid <= '0;
      cli.rsp_data  <= '0;
      ptr           <= TAGW'(NREQ - 1);
      for (int s = 0; s <= LAT; s++) begin
        tag_v[s]  <= 1'b0;
        tag_id[s] <= '0;
      end
      for (int i = 0; i < NREQ; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      if (accept) begin
        mul_a <= sel_a;
        mul_b <= sel_b;
        ptr   <= grant_idx;
      end else begin
        mul_a <= '0;
        mul_b <= '0;
      end

      tag_v[0]  <= accept;
      tag_id[0] <= accept ? grant_idx : '0;
      for (int s = 1; s <= LAT; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end

      if (tag_v[LAT]) begin
        cli.rsp_valid <= rsp_oh;
        cli.rsp_data  <= mul_prod;
      end else begin
        cli.rsp_valid <= '0;
      end

      for (int i = 0; i < NREQ; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          cnt[i] <= cnt[i] + 3'd1;
        end else if (dec_vec[i] && !inc_vec[i]) begin
          cnt[i] <= cnt[i] - 3'd1;
        end
      end
    end
  end

  always_comb begin
    cli.busy = |cli.rsp_valid;
    for (int s = 0; s <= LAT; s++) begin
      cli.busy = cli.busy | tag_v[s];
    end
  end

  // Credit bounds: never above MAXOUT, never a return without an op in flight.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        assert (cnt[i] <= 3'(MAXOUT));
        assert (!(dec_vec[i] && !inc_vec[i] && (cnt[i] == 3'd0)));
      end
    end
  end

endmodule
